fx_neg2ln_sqrt: RTL and testbench

FX_NEG2LN_SQRT -- requirements
Module: fx_neg2ln_sqrt

---
 rtl/fx_neg2ln_sqrt_if.sv | 38 +++
 rtl/fx_neg2ln_sqrt.sv | 183 ++++++++++++++++++
 tb/tb_fx_neg2ln_sqrt.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/fx_neg2ln_sqrt_if.sv
// Handshake bundle for the Box-Muller radius stage: an ln(u) word comes in,
// the radius sqrt(-2*ln(u)) and its status flags go out.
interface fx_neg2ln_sqrt_if #(
  parameter int WIDTH = 32
);
  logic             valid_in;
  logic             in_ready;
  logic [WIDTH-1:0] ln_in;
  logic             valid_out;
  logic             ready_in;
  logic [WIDTH-1:0] r_out;
  logic             err_pos;
  logic             sat;

  // Upstream/downstream side: offers ln words and accepts radii
  modport master (
    output valid_in,
    output ln_in,
    output ready_in,
    input  in_ready,
    input  valid_out,
    input  r_out,
    input  err_pos,
    input  sat
  );

  // Radius block side
  modport slave (
    input  valid_in,
    input  ln_in,
    input  ready_in,
    output in_ready,
    output valid_out,
    output r_out,
    output err_pos,
    output sat
  );
endinterface

// File: rtl/fx_neg2ln_sqrt.sv
// Radius stage of a fixed-point Box-Muller generator.
// Takes a signed QFRAC-fraction ln(u) word and returns the truncated
// unsigned square root of -2*ln(u). The root is found with a bit-serial
// restoring algorithm that produces one result bit per cycle, MSB first.
// Inputs above zero cannot come from a valid ln LUT; they yield 0 with
// err_pos set. The most-negative input cannot be doubled in WIDTH bits, so
// it is clamped to all-ones with sat set.
module fx_neg2ln_sqrt #(
  parameter int WIDTH = 32,
  parameter int QFRAC = 16,
  parameter int ITER  = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  fx_neg2ln_sqrt_if.slave      bus
);

  localparam int RADW = WIDTH + QFRAC;
  localparam int REMW = ITER + 2;
  localparam int CNTW = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_nextState;

  logic [WIDTH-1:0] r_lnIn;
  logic [RADW-1:0]  r_radicand;
  logic [REMW-1:0]  r_rem;
  logic [ITER-1:0]  r_root;
  logic [CNTW-1:0]  r_iterCnt;
  logic [WIDTH-1:0] r_rOut;
  logic             r_errPos;
  logic             r_sat;

  logic             w_inReady;
  logic             w_validOut;
  logic             w_accept;
  logic             w_release;
  logic             w_lastIter;

  logic             w_lnPositive;
  logic             w_lnMostNeg;
  logic [WIDTH-1:0] w_negLn;
  logic [WIDTH-1:0] w_m;
  logic             w_prepErr;
  logic             w_prepSat;

  logic [REMW-1:0]  w_remShift;
  logic [REMW-1:0]  w_trial;
  logic [REMW-1:0]  w_remDiff;
  logic             w_bitOne;
  logic [REMW-1:0]  w_remNext;
  logic [ITER-1:0]  w_rootNext;

  assign w_accept   = w_inReady && bus.valid_in;
  assign w_release  = (r_state == DONE) && bus.ready_in;
  assign w_lastIter = (r_state == CALC) && (r_iterCnt == CNTW'(ITER - 1));

  // Classify the captured word: positive, most-negative or ordinary negative
  assign w_lnPositive = !r_lnIn[WIDTH-1] && (r_lnIn != '0);
  assign w_lnMostNeg  = (r_lnIn == {1'b1, {(WIDTH-1){1'b0}}});
  assign w_negLn      = -r_lnIn;

  // Build m = -2*ln as an unsigned word, with the two out-of-range cases clamped
  always_comb begin
    w_m       = '0;
    w_prepErr = 1'b0;
    w_prepSat = 1'b0;
    if (w_lnPositive) begin
      w_m       = '0;
      w_prepErr = 1'b1;
    end else if (w_lnMostNeg) begin
      w_m       = '1;
      w_prepSat = 1'b1;
    end else begin
      w_m = w_negLn << 1;
    end
  end

  // One restoring square-root step: bring down two radicand bits, try root*4+1
  always_comb begin
    w_remShift = (r_rem << 2) | REMW'(r_radicand[RADW-1 -: 2]);
    w_trial    = {r_root, 2'b01};
    w_remDiff  = w_remShift - w_trial;
    w_bitOne   = (w_remShift >= w_trial);
    w_remNext  = w_bitOne ? w_remDiff : w_remShift;
    w_rootNext = {r_root[ITER-2:0], w_bitOne};
  end

  // State register; reset aborts whatever operation is in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state: accept in IDLE, one PREP cycle, ITER CALC cycles, hold DONE until taken
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (w_accept)   w_nextState = PREP;
      PREP:                 w_nextState = CALC;
      CALC: if (w_lastIter) w_nextState = DONE;
      DONE: if (w_release)  w_nextState = IDLE;
      default:              w_nextState = IDLE;
    endcase
  end

  // Handshake outputs are pure decodes of the state
  always_comb begin
    w_inReady  = 1'b0;
    w_validOut = 1'b0;
    case (r_state)
      IDLE:    w_inReady  = 1'b1;
      DONE:    w_validOut = 1'b1;
      default: begin
        w_inReady  = 1'b0;
        w_validOut = 1'b0;
      end
    endcase
  end

  assign bus.in_ready  = w_inReady;
  assign bus.valid_out = w_validOut;
  assign bus.r_out     = r_rOut;
  assign bus.err_pos   = r_errPos;
  assign bus.sat       = r_sat;

  // Datapath: capture on accept, prepare radicand, iterate, latch the finished root
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lnIn     <= '0;
      r_radicand <= '0;
      r_rem      <= '0;
      r_root     <= '0;
      r_iterCnt  <= '0;
      r_rOut     <= '0;
      r_errPos   <= 1'b0;
      r_sat      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_lnIn   <= bus.ln_in;
            r_errPos <= 1'b0;
            r_sat    <= 1'b0;
          end
        end
        PREP: begin
          r_radicand <= {w_m, {QFRAC{1'b0}}};
          r_rem      <= '0;
          r_root     <= '0;
          r_iterCnt  <= '0;
          r_errPos   <= w_prepErr;
          r_sat      <= w_prepSat;
        end
        CALC: begin
          r_radicand <= r_radicand << 2;
          r_rem      <= w_remNext;
          r_root     <= w_rootNext;
          if (w_lastIter) begin
            r_iterCnt <= '0;
            r_rOut    <= WIDTH'(w_rootNext);
          end else begin
            r_iterCnt <= r_iterCnt + CNTW'(1);
          end
        end
        default: begin
          r_rOut <= r_rOut;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fx_neg2ln_sqrt.sv
// Self-checking bench for fx_neg2ln_sqrt: directed vector table, stall,
// mid-computation reset and a randomised run against a reference sqrt.
module tb_fx_neg2ln_sqrt;

  logic clk;
  logic rst;

  fx_neg2ln_sqrt_if #(.WIDTH(32)) bus ();

  fx_neg2ln_sqrt #(
    .WIDTH(32),
    .QFRAC(16),
    .ITER (24)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] ln;
    logic [31:0] expR;
    logic        expErr;
    logic        expSat;
  } vec_t;

  vec_t vecs [10];

  int checks = 0;
  int errors = 0;
  int inCount = 0;
  int outCount = 0;

  // Free-running clock, 10 time units per period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a bounded wait is ever mis-coded
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Wait for in_ready, then present one ln word for exactly one edge
  task automatic applyStimulus(input logic [31:0] ln);
    int n;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("in_ready_before_send", {31'b0, bus.in_ready}, 32'd1);
    bus.valid_in = 1'b1;
    bus.ln_in    = ln;
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
  endtask

  // Count edges after the accepting edge until valid_out rises (bounded)
  task automatic waitValid(output int lat);
    lat = 0;
    while (!bus.valid_out && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("valid_out_seen", {31'b0, bus.valid_out}, 32'd1);
  endtask

  function automatic logic [31:0] refRadius(input logic [31:0] ln);
    int               s;
    longint unsigned  m;
    longint unsigned  rad;
    longint unsigned  lo;
    longint unsigned  hi;
    longint unsigned  mid;
    s = int'(ln);
    if (s > 0)                     m = 0;
    else if (ln == 32'h8000_0000)  m = 64'hFFFF_FFFF;
    else                           m = 64'(-longint'(s)) * 2;
    rad = m << 16;
    lo = 0;
    hi = 64'd1 << 25;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= rad) lo = mid;
      else                  hi = mid;
    end
    return 32'(lo);
  endfunction

  initial begin
    int lat;
    int vHigh;
    int k;
    logic [31:0] ln;
    logic [31:0] expR;

    vecs[0] = '{32'hFFFF4E8E, 32'h00012D6A, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF0000, 32'h00016A09, 1'b0, 1'b0};
    vecs[2] = '{32'h00000000, 32'h00000000, 1'b0, 1'b0};
    vecs[3] = '{32'h00010000, 32'h00000000, 1'b1, 1'b0};
    vecs[4] = '{32'hFFFE0000, 32'h00020000, 1'b0, 1'b0};
    vecs[5] = '{32'h80000000, 32'h00FFFFFF, 1'b0, 1'b1};
    vecs[6] = '{32'hFFFFFFFF, 32'h0000016A, 1'b0, 1'b0};
    vecs[7] = '{32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b0};
    vecs[8] = '{32'h80000001, 32'h00FFFFFF, 1'b0, 1'b0};
    vecs[9] = '{32'h00000001, 32'h00000000, 1'b1, 1'b0};

    rst          = 1'b1;
    bus.valid_in = 1'b0;
    bus.ln_in    = '0;
    bus.ready_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    checkOutput("reset_in_ready",  {31'b0, bus.in_ready},  32'd1);
    checkOutput("reset_valid_out", {31'b0, bus.valid_out}, 32'd0);
    checkOutput("reset_r_out",     bus.r_out,              32'd0);
    checkOutput("reset_err_pos",   {31'b0, bus.err_pos},   32'd0);
    checkOutput("reset_sat",       {31'b0, bus.sat},       32'd0);

    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].ln);
      waitValid(lat);
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'd25);
      checkOutput($sformatf("vec%0d_r_out", i),   bus.r_out, vecs[i].expR);
      checkOutput($sformatf("vec%0d_err_pos", i), {31'b0, bus.err_pos}, {31'b0, vecs[i].expErr});
      checkOutput($sformatf("vec%0d_sat", i),     {31'b0, bus.sat},     {31'b0, vecs[i].expSat});
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d_valid_drop", i), {31'b0, bus.valid_out}, 32'd0);
      checkOutput($sformatf("vec%0d_in_ready", i),   {31'b0, bus.in_ready},  32'd1);
    end

    $display("[TB] downstream stall with ignored input pulses");
    bus.ready_in = 1'b0;
    applyStimulus(32'hFFFF0000);
    waitValid(lat);
    for (int c = 0; c < 10; c++) begin
      bus.valid_in = c[0];
      bus.ln_in    = 32'h00010000;
      @(posedge clk); #1;
      checkOutput($sformatf("stall%0d_r_out", c),     bus.r_out,              32'h00016A09);
      checkOutput($sformatf("stall%0d_err_pos", c),   {31'b0, bus.err_pos},   32'd0);
      checkOutput($sformatf("stall%0d_valid_out", c), {31'b0, bus.valid_out}, 32'd1);
      checkOutput($sformatf("stall%0d_in_ready", c),  {31'b0, bus.in_ready},  32'd0);
    end
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b1;
    @(posedge clk); #1;
    checkOutput("stall_release_valid", {31'b0, bus.valid_out}, 32'd0);
    checkOutput("stall_release_ready", {31'b0, bus.in_ready},  32'd1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("stall_no_ghost_op", {31'b0, bus.in_ready}, 32'd1);

    $display("[TB] reset during CALC");
    applyStimulus(32'hFFFF4E8E);
    repeat (11) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("midreset_in_ready",  {31'b0, bus.in_ready},  32'd1);
    checkOutput("midreset_valid_out", {31'b0, bus.valid_out}, 32'd0);
    checkOutput("midreset_r_out",     bus.r_out,              32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    vHigh = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.valid_out) vHigh++;
    end
    checkOutput("midreset_no_output", 32'(vHigh), 32'd0);
    applyStimulus(32'hFFFF0000);
    waitValid(lat);
    checkOutput("postreset_latency", 32'(lat), 32'd25);
    checkOutput("postreset_r_out",   bus.r_out, 32'h00016A09);
    @(posedge clk); #1;

    $display("[TB] random operands with random backpressure");
    for (int i = 0; i < 1000; i++) begin
      ln   = -($urandom & 32'h7FFF_FFFF);
      expR = refRadius(ln);
      bus.ready_in = 1'($urandom_range(0, 1));
      applyStimulus(ln);
      inCount++;
      waitValid(lat);
      checkOutput($sformatf("rand%0d_r_out ln=0x%0h", i, ln), bus.r_out, expR);
      checkOutput($sformatf("rand%0d_err_pos", i), {31'b0, bus.err_pos}, 32'd0);
      k = 0;
      while (bus.valid_out && k < 50) begin
        bus.ready_in = (k >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        k++;
      end
      if (!bus.valid_out) outCount++;
      bus.ready_in = 1'b1;
    end
    checkOutput("rand_count_in_out", 32'(outCount), 32'(inCount));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
